// File: rtl/joybus_rx_deserializer.sv
// rtl/joybus_rx_deserializer.sv - Joybus receive deserializer: bit strobes to bytes and frame status
module joybus_rx_deserializer #(
  parameter int IDLE_TIMEOUT = 64,
  parameter int MAX_BYTES    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_en,
  input  logic       derived_signal,
  input  logic       derived_clk,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic [3:0] byte_count,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_END  = 2'd2;

  localparam logic [7:0] TO_LAST  = 8'(IDLE_TIMEOUT - 1);
  localparam logic [3:0] MAX_BYTE = 4'(MAX_BYTES);

  logic       dclk_s1_q, dclk_s2_q, dclk_prev_q;
  logic       dsig_s1_q, dsig_s2_q;

  logic [1:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] timeout_q, timeout_d;
  logic       overflow_q, overflow_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_byte_valid_q, rx_byte_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q, frame_err_d;
  logic [3:0] byte_count_q, byte_count_d;

  logic       strobe;
  logic       bit_in;
  logic [7:0] shift_next;

  // Two-flop synchronizers plus a history flop for falling-edge detect; all idle high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dclk_s1_q   <= 1'b1;
      dclk_s2_q   <= 1'b1;
      dclk_prev_q <= 1'b1;
      dsig_s1_q   <= 1'b1;
      dsig_s2_q   <= 1'b1;
    end else begin
      dclk_s1_q   <= derived_clk;
      dclk_s2_q   <= dclk_s1_q;
      dclk_prev_q <= dclk_s2_q;
      dsig_s1_q   <= derived_signal;
      dsig_s2_q   <= dsig_s1_q;
    end
  end

  assign strobe     = ~dclk_s2_q & dclk_prev_q;
  assign bit_in     = dsig_s2_q;
  assign shift_next = {shift_q[6:0], bit_in};

  // Frame FSM: bit assembly, byte emission, idle timeout and end-of-frame status
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    timeout_d       = timeout_q;
    overflow_d      = overflow_q;
    rx_byte_d       = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    frame_done_d    = 1'b0;
    frame_err_d     = frame_err_q;
    byte_count_d    = byte_count_q;

    if (!rx_en) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      timeout_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (strobe) begin
            state_d      = ST_RECV;
            shift_d      = {7'd0, bit_in};
            bit_cnt_d    = 4'd1;
            byte_count_d = 4'd0;
            frame_err_d  = 1'b0;
            timeout_d    = 8'd0;
            overflow_d   = 1'b0;
          end
        end
        ST_RECV: begin
          // A strobe beats a timeout expiring in the same cycle
          if (strobe) begin
            shift_d   = shift_next;
            timeout_d = 8'd0;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (byte_count_q >= MAX_BYTE) begin
                overflow_d = 1'b1;
              end else begin
                rx_byte_d       = shift_next;
                rx_byte_valid_d = 1'b1;
                byte_count_d    = byte_count_q + 4'd1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (timeout_q == TO_LAST) begin
            state_d      = ST_END;
            timeout_d    = 8'd0;
            frame_done_d = 1'b1;
            // Good frame: whole bytes plus exactly one trailing stop bit of 1
            frame_err_d  = !((bit_cnt_q == 4'd1) && shift_q[0] &&
                             (byte_count_q != 4'd0) && !overflow_q);
          end else begin
            timeout_d = timeout_q + 8'd1;
          end
        end
        ST_END: begin
          // Strobes landing here are dropped on purpose
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      shift_q         <= 8'd0;
      bit_cnt_q       <= 4'd0;
      timeout_q       <= 8'd0;
      overflow_q      <= 1'b0;
      rx_byte_q       <= 8'd0;
      rx_byte_valid_q <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      byte_count_q    <= 4'd0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      timeout_q       <= timeout_d;
      overflow_q      <= overflow_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      frame_done_q    <= frame_done_d;
      frame_err_q     <= frame_err_d;
      byte_count_q    <= byte_count_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_byte_valid_q;
  assign frame_done    = frame_done_q;
  assign frame_err     = frame_err_q;
  assign byte_count    = byte_count_q;
  assign busy          = (state_q == ST_RECV) || (state_q == ST_END);

endmodule

// File: tb/tb_joybus_rx_deserializer.sv
// tb/tb_joybus_rx_deserializer.sv - directed bench for joybus_rx_deserializer
module tb_joybus_rx_deserializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_en;
  logic       derived_signal;
  logic       derived_clk;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       frame_done;
  logic       frame_err;
  logic [3:0] byte_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_bytes[$];
  int         fd_cnt = 0;
  logic       fe_seen = 1'b0;
  logic [3:0] bc_seen = 4'd0;

  joybus_rx_deserializer #(.IDLE_TIMEOUT(64), .MAX_BYTES(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_en(rx_en),
    .derived_signal(derived_signal),
    .derived_clk(derived_clk),
    .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .byte_count(byte_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Record emitted bytes and frame status away from the rising edge
  always @(negedge clk) begin
    if (rx_byte_valid) q_bytes.push_back(rx_byte);
    if (frame_done) begin
      fd_cnt  = fd_cnt + 1;
      fe_seen = frame_err;
      bc_seen = byte_count;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    derived_signal = b;
    wait_cyc(1);
    derived_clk = 1'b0;
    wait_cyc(4);
    derived_clk = 1'b1;
    wait_cyc(3);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic wait_frame(input int base, input string name);
    int n;
    n = 0;
    while (fd_cnt == base && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fd_cnt == base) begin
      errors++;
      $display("FAIL %s frame_done got none want 1 pulse", name);
    end
    wait_cyc(1);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx_en = 1'b1;
    derived_clk = 1'b1;
    derived_signal = 1'b1;
    wait_cyc(3);
    checks++;
    if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h want 00", rx_byte); end
    checks++;
    if ({rx_byte_valid, frame_done, frame_err, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {rx_byte_valid, frame_done, frame_err, busy});
    end
    checks++;
    if (byte_count !== 4'd0) begin errors++; $display("FAIL reset_byte_count got %0d want 0", byte_count); end
    reset_n = 1'b1;
    wait_cyc(10);
    checks++;
    if ({busy, rx_byte_valid} !== 2'b00 || q_bytes.size() != 0) begin
      errors++; $display("FAIL reset_release_strobe got busy=%b bytes=%0d want 0 0", busy, q_bytes.size());
    end
  endtask

  task automatic test_single_byte;
    int bq, bf;
    logic [7:0] got;
    bq = q_bytes.size();
    bf = fd_cnt;
    send_byte(8'h01);
    send_bit(1'b1);
    wait_frame(bf, "single_frame");
    checks++;
    if (q_bytes.size() - bq != 1) begin errors++; $display("FAIL single_count got %0d want 1", q_bytes.size() - bq); end
    got = (q_bytes.size() > bq) ? q_bytes[bq] : 8'hxx;
    checks++;
    if (got !== 8'h01) begin errors++; $display("FAIL single_byte got %h want 01", got); end
    checks++;
    if (fe_seen !== 1'b0 || bc_seen !== 4'd1) begin
      errors++; $display("FAIL single_status got err=%b cnt=%0d want 0 1", fe_seen, bc_seen);
    end
    wait_cyc(20);
    checks++;
    if (frame_err !== 1'b0 || byte_count !== 4'd1 || busy !== 1'b0 || fd_cnt - bf != 1) begin
      errors++; $display("FAIL single_hold got err=%b cnt=%0d busy=%b frames=%0d want 0 1 0 1",
                         frame_err, byte_count, busy, fd_cnt - bf);
    end
  endtask

  task automatic test_two_bytes;
    int bq, bf;
    logic [15:0] got;
    bq = q_bytes.size();
    bf = fd_cnt;
    send_byte(8'hFF);
    send_byte(8'h00);
    send_bit(1'b1);
    wait_frame(bf, "two_frame");
    got = (q_bytes.size() >= bq + 2) ? {q_bytes[bq], q_bytes[bq+1]} : 16'hxxxx;
    checks++;
    if (q_bytes.size() - bq != 2 || got !== 16'hFF00) begin
      errors++; $display("FAIL two_bytes got n=%0d %h want 2 ff00", q_bytes.size() - bq, got);
    end
    checks++;
    if (fe_seen !== 1'b0 || bc_seen !== 4'd2) begin
      errors++; $display("FAIL two_status got err=%b cnt=%0d want 0 2", fe_seen, bc_seen);
    end
  endtask

  task automatic test_no_stop;
    int bq, bf;
    logic [7:0] got;
    bq = q_bytes.size();
    bf = fd_cnt;
    send_byte(8'h5A);
    wait_frame(bf, "nostop_frame");
    got = (q_bytes.size() > bq) ? q_bytes[bq] : 8'hxx;
    checks++;
    if (got !== 8'h5A) begin errors++; $display("FAIL nostop_byte got %h want 5a", got); end
    checks++;
    if (fe_seen !== 1'b1 || bc_seen !== 4'd1) begin
      errors++; $display("FAIL nostop_status got err=%b cnt=%0d want 1 1", fe_seen, bc_seen);
    end
    bf = fd_cnt;
    send_byte(8'h5A);
    send_bit(1'b0);
    wait_frame(bf, "stop0_frame");
    checks++;
    if (fe_seen !== 1'b1) begin errors++; $display("FAIL stop0_err got %b want 1", fe_seen); end
  endtask

  task automatic test_overflow;
    int bq, bf;
    logic [7:0] got;
    bq = q_bytes.size();
    bf = fd_cnt;
    send_byte(8'h10);
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL ovf_err_cleared got %b want 0", frame_err); end
    for (int i = 1; i < 9; i++) send_byte(8'h10 + 8'(i));
    send_bit(1'b1);
    wait_frame(bf, "ovf_frame");
    checks++;
    if (q_bytes.size() - bq != 8) begin errors++; $display("FAIL ovf_count got %0d want 8", q_bytes.size() - bq); end
    got = (q_bytes.size() > 0) ? q_bytes[q_bytes.size()-1] : 8'hxx;
    checks++;
    if (got !== 8'h17) begin errors++; $display("FAIL ovf_last_byte got %h want 17", got); end
    checks++;
    if (fe_seen !== 1'b1 || bc_seen !== 4'd8) begin
      errors++; $display("FAIL ovf_status got err=%b cnt=%0d want 1 8", fe_seen, bc_seen);
    end
  endtask

  task automatic test_latency;
    int bf, lat;
    logic [7:0] v;
    v = 8'h3C;
    bf = fd_cnt;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    derived_signal = v[0];
    wait_cyc(1);
    derived_clk = 1'b0;
    lat = 0;
    while (!rx_byte_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 3 || rx_byte !== 8'h3C) begin
      errors++; $display("FAIL latency got %0d cycles byte %h want 3 3c", lat, rx_byte);
    end
    wait_cyc(1);
    checks++;
    if (rx_byte_valid !== 1'b0) begin errors++; $display("FAIL valid_width got %b want 0", rx_byte_valid); end
    wait_cyc(2);
    derived_clk = 1'b1;
    wait_cyc(4);
    send_bit(1'b1);
    wait_frame(bf, "latency_frame");
    checks++;
    if (fe_seen !== 1'b0 || bc_seen !== 4'd1) begin
      errors++; $display("FAIL latency_status got err=%b cnt=%0d want 0 1", fe_seen, bc_seen);
    end
  endtask

  task automatic test_rx_en_drop;
    int bf;
    bf = fd_cnt;
    send_byte(8'hC3);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_en = 1'b0;
    wait_cyc(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rxen_busy got %b want 0", busy); end
    wait_cyc(150);
    checks++;
    if (fd_cnt != bf) begin errors++; $display("FAIL rxen_no_frame got %0d want 0", fd_cnt - bf); end
    checks++;
    if (byte_count !== 4'd1 || rx_byte !== 8'hC3) begin
      errors++; $display("FAIL rxen_hold got cnt=%0d byte=%h want 1 c3", byte_count, rx_byte);
    end
    rx_en = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_reset_mid_frame;
    int bq, bf;
    logic [7:0] got;
    bf = fd_cnt;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (rx_byte !== 8'h00 || byte_count !== 4'd0 || busy !== 1'b0 || frame_err !== 1'b0 || rx_byte_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got byte=%h cnt=%0d busy=%b err=%b vld=%b want all 0",
                         rx_byte, byte_count, busy, frame_err, rx_byte_valid);
    end
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(100);
    checks++;
    if (fd_cnt != bf) begin errors++; $display("FAIL midreset_no_frame got %0d want 0", fd_cnt - bf); end
    bq = q_bytes.size();
    send_byte(8'hA5);
    send_bit(1'b1);
    wait_frame(bf, "after_reset_frame");
    got = (q_bytes.size() > bq) ? q_bytes[bq] : 8'hxx;
    checks++;
    if (got !== 8'hA5 || fe_seen !== 1'b0) begin
      errors++; $display("FAIL after_reset got byte=%h err=%b want a5 0", got, fe_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_bytes();
    test_no_stop();
    test_overflow();
    test_latency();
    test_rx_en_drop();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
